mem_port_arbiter: RTL and testbench

Shares one single-port 64 KiB SRAM between the instruction-fetch stage and the MEM stage of the 5-stage RISC-V pipeline, so the design can run from a unified memory. Each cycle it grants at most one requester, drives the SRAM port, routes returning read data to the owner one cycle later, and raises per-side stall signals. The Hazard_Detection logic consumes these stalls. A bounded-fairness counter keeps the fetch side from being starved.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/arb_grant_logic.sv | 22 ++
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 16;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned STARVE_CNT_W   = 4;
  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned BE_W           = 4;

  // Which requester owns the read data returning from the SRAM this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  // True when the data side has used up its allowed streak of grants.
  function automatic logic streak_full(input logic [STARVE_CNT_W-1:0] streak,
                                       input int unsigned           limit);
    return streak == STARVE_CNT_W'(limit);
  endfunction

endpackage

// File: rtl/arb_grant_logic.sv
// Combinational grant decision: data wins unless fetch has waited through a full streak.
module arb_grant_logic
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                    if_req,
  input  logic                    dm_req,
  input  logic [STARVE_CNT_W-1:0] streak,
  output logic                    if_gnt,
  output logic                    dm_gnt
);

  logic starved_c;

  always_comb begin
    starved_c = if_req && streak_full(streak, STARVE_MAX);
    dm_gnt    = dm_req && !starved_c;
    if_gnt    = if_req && !dm_gnt;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and the MEM stage.
// Build option: ARB_STARVE_GUARD_EN enables the fetch-starvation streak counter.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic [BE_W-1:0]   dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              if_stall,
  output logic              dm_stall,
  output logic [BE_W-1:0]   mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_e                  state_q, state_d;
  logic [STARVE_CNT_W-1:0] streak;

  arb_grant_logic #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .if_req (if_req),
    .dm_req (dm_req),
    .streak (streak),
    .if_gnt (if_gnt),
    .dm_gnt (dm_gnt)
  );

`ifdef ARB_STARVE_GUARD_EN
  logic [STARVE_CNT_W-1:0] streak_q, streak_d;

  // Count data grants taken while fetch waits; any fetch grant or idle fetch resets it.
  always_comb begin
    streak_d = streak_q;
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (dm_gnt && (streak_q < STARVE_CNT_W'(STARVE_MAX))) begin
      streak_d = streak_q + STARVE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign streak = streak_q;
`else
  // Without the guard the streak never matches a legal limit, so data always wins.
  assign streak = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next owner, SRAM command, and return-data routing.
  always_comb begin
    state_d   = OWN_NONE;
    mem_w_en  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      state_d  = OWN_IF;
      mem_addr = if_addr;
    end else if (dm_gnt) begin
      mem_addr = dm_addr;
      if (dm_we == '0) begin
        state_d = OWN_DM;
      end else begin
        mem_w_en  = dm_we;
        mem_wdata = dm_wdata;
      end
    end

    if_rvalid = (state_q == OWN_IF);
    dm_rvalid = (state_q == OWN_DM);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    dm_rdata  = dm_rvalid ? mem_rdata : '0;

    if_stall  = if_req && !if_gnt;
    dm_stall  = dm_req && !dm_gnt;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural 64 KiB SRAM.
module tb_mem_port_arbiter;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  localparam logic [1:0] O_NONE = 2'd0;
  localparam logic [1:0] O_IF   = 2'd1;
  localparam logic [1:0] O_DM   = 2'd2;

  typedef struct {
    logic        ir;
    logic [15:0] ia;
    logic        dr;
    logic [3:0]  we;
    logic [15:0] da;
    logic [31:0] wd;
    logic        eig;
    logic        edg;
    logic        kill;
  } vec_t;

  typedef struct {
    logic [1:0]  own;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic [3:0]  dm_we;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        if_stall;
  logic        dm_stall;
  logic [3:0]  mem_w_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] sram [0:16383];
  logic [31:0] shd  [0:16383];
  exp_t        sb[$];
  vec_t        vecs[$];
  int          n_tests;
  int          n_fail;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .if_stall  (if_stall),
    .dm_stall  (dm_stall),
    .mem_w_en  (mem_w_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'h9E37_0000 ^ (32'(i) * 32'h0001_0003);
  endfunction

  // Synchronous SRAM: byte-enable write and registered read in the same edge.
  initial begin
    mem_rdata = '0;
    for (int i = 0; i < 16384; i++) sram[i] = init_word(i);
    forever begin
      @(posedge clk);
      for (int b = 0; b < 4; b++)
        if (mem_w_en[b]) sram[mem_addr[15:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= sram[mem_addr[15:2]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic ir, input logic [15:0] ia, input logic dr,
                              input logic [3:0] we, input logic [15:0] da,
                              input logic [31:0] wd, input logic eig, input logic edg,
                              input logic kill);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.we = we; v.da = da; v.wd = wd;
    v.eig = eig; v.edg = edg; v.kill = kill;
    return v;
  endfunction

  // One arbitration cycle: drive, check last cycle's read return, check grant/SRAM port.
  task automatic apply(input vec_t v);
    exp_t        e;
    logic        is_wr;
    logic [15:0] exp_addr;
    logic [3:0]  exp_we;
    @(negedge clk);
    rst = 1'b1;
    if_req = v.ir; if_addr = v.ia;
    dm_req = v.dr; dm_we = v.we; dm_addr = v.da; dm_wdata = v.wd;
    #1;
    if (sb.size() > 0) e = sb.pop_front();
    else begin e.own = O_NONE; e.data = '0; end
    chk("if_rvalid", 32'(if_rvalid), 32'(e.own == O_IF));
    chk("if_rdata",  if_rdata, (e.own == O_IF) ? e.data : 32'h0);
    chk("dm_rvalid", 32'(dm_rvalid), 32'(e.own == O_DM));
    chk("dm_rdata",  dm_rdata, (e.own == O_DM) ? e.data : 32'h0);
    chk("if_gnt",   32'(if_gnt),   32'(v.eig));
    chk("dm_gnt",   32'(dm_gnt),   32'(v.edg));
    chk("if_stall", 32'(if_stall), 32'(v.ir && !v.eig));
    chk("dm_stall", 32'(dm_stall), 32'(v.dr && !v.edg));
    is_wr    = v.edg && (v.we != 4'h0);
    exp_addr = v.eig ? v.ia : (v.edg ? v.da : 16'h0);
    exp_we   = is_wr ? v.we : 4'h0;
    chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
    chk("mem_w_en", 32'(mem_w_en), 32'(exp_we));
    if (is_wr || !(v.eig || v.edg))
      chk("mem_wdata", mem_wdata, is_wr ? v.wd : 32'h0);
    if (is_wr)
      for (int b = 0; b < 4; b++)
        if (v.we[b]) shd[v.da[15:2]][8*b +: 8] = v.wd[8*b +: 8];
    e.own = O_NONE; e.data = '0;
    if (v.eig) begin
      e.own = O_IF; e.data = shd[v.ia[15:2]];
    end else if (v.edg && !is_wr) begin
      e.own = O_DM; e.data = shd[v.da[15:2]];
    end
    if (v.kill) begin
      #1 rst = 1'b0;
      e.own = O_NONE; e.data = '0;
    end
    sb.push_back(e);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = '0; dm_addr = '0; dm_wdata = '0;
    for (int i = 0; i < 16384; i++) shd[i] = init_word(i);

    // Fetch only, same address three times, then contested read.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 16'h0010, 0, 4'h0, 16'h0, 32'h0, 1, 0, 0));
    vecs.push_back(mk(1, 16'h0020, 1, 4'h0, 16'h0100, 32'h0, 0, 1, 0));
    vecs.push_back(mk(0, 16'h0, 0, 4'h0, 16'h0, 32'h0, 0, 0, 0));
    // Six contested cycles: fairness override on the fifth when guarded.
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(1, 16'h0030, 1, 4'h0, 16'h0104, 32'h0, GUARD && i == 4, !(GUARD && i == 4), 0));
    vecs.push_back(mk(0, 16'h0, 0, 4'h0, 16'h0, 32'h0, 0, 0, 0));
    // Partial write then read-back of the same word.
    vecs.push_back(mk(0, 16'h0, 1, 4'b0011, 16'h0200, 32'hAABBCCDD, 0, 1, 0));
    vecs.push_back(mk(0, 16'h0, 1, 4'h0, 16'h0200, 32'h0, 0, 1, 0));
    vecs.push_back(mk(0, 16'h0, 0, 4'h0, 16'h0, 32'h0, 0, 0, 0));
    // Contested full write, then fetch reads the written word.
    vecs.push_back(mk(1, 16'h0040, 1, 4'hF, 16'h0300, 32'h12345678, 0, 1, 0));
    vecs.push_back(mk(1, 16'h0300, 0, 4'h0, 16'h0, 32'h0, 1, 0, 0));
    // Alternating back-to-back reads.
    vecs.push_back(mk(0, 16'h0, 1, 4'h0, 16'h0400, 32'h0, 0, 1, 0));
    vecs.push_back(mk(1, 16'h0404, 0, 4'h0, 16'h0, 32'h0, 1, 0, 0));
    vecs.push_back(mk(0, 16'h0, 1, 4'h0, 16'h0404, 32'h0, 0, 1, 0));
    vecs.push_back(mk(0, 16'h0, 0, 4'h0, 16'h0, 32'h0, 0, 0, 0));
    // Reset during a pending fetch read, then contested data grant.
    vecs.push_back(mk(1, 16'h0050, 0, 4'h0, 16'h0, 32'h0, 1, 0, 1));
    vecs.push_back(mk(1, 16'h0060, 1, 4'h0, 16'h0108, 32'h0, 0, 1, 0));
    vecs.push_back(mk(1, 16'h0060, 1, 4'h0, 16'h0108, 32'h0, 0, 1, 0));
    // Reset with a streak built up: afterwards a full streak is allowed again.
    vecs.push_back(mk(1, 16'h0060, 1, 4'h0, 16'h0108, 32'h0, 0, 1, 1));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 16'h0070, 1, 4'h0, 16'h010C, 32'h0, GUARD && i == 4, !(GUARD && i == 4), 0));
    vecs.push_back(mk(0, 16'h0, 0, 4'h0, 16'h0, 32'h0, 0, 0, 0));

    // Reset state with idle inputs.
    @(negedge clk);
    #1;
    chk("rst_if_gnt",    32'(if_gnt),    32'h0);
    chk("rst_dm_gnt",    32'(dm_gnt),    32'h0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'h0);
    chk("rst_dm_rvalid", 32'(dm_rvalid), 32'h0);
    chk("rst_if_rdata",  if_rdata,       32'h0);
    chk("rst_dm_rdata",  dm_rdata,       32'h0);
    chk("rst_stalls",    32'({if_stall, dm_stall}), 32'h0);
    chk("rst_mem_w_en",  32'(mem_w_en),  32'h0);
    chk("rst_mem_addr",  32'(mem_addr),  32'h0);
    chk("rst_mem_wdata", mem_wdata,      32'h0);

    // Grants follow requests during reset but no read is delivered.
    if_req = 1'b1; dm_req = 1'b1; dm_addr = 16'h0100;
    #1;
    chk("rst_cont_dm_gnt",   32'(dm_gnt),   32'h1);
    chk("rst_cont_if_stall", 32'(if_stall), 32'h1);
    chk("rst_cont_if_gnt",   32'(if_gnt),   32'h0);
    @(negedge clk);
    if_req = 1'b0; dm_req = 1'b0; dm_addr = '0;
    #1;
    chk("rst_hold_dm_rvalid", 32'(dm_rvalid), 32'h0);

    sb.push_back('{own: O_NONE, data: 32'h0});
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
